move_queue: RTL
===============

// Module: move_queue
//
// PURPOSE
//   Parametrised circular FIFO for maze move codes (2-bit directions by default).
//   Sits between the path generator (enqueue side) and the maze walker (dequeue side).
//   Generalises the fixed 256x2 queue:
//     - configurable width and depth
//     - per-entry enqueue handshake instead of bulk array load
//     - simultaneous enq/deq, occupancy count, sticky error flags
//
// PARAMETERS
//   DATA_W  2    width of one queue entry (move code)
//   DEPTH   256  number of entries; any value >= 2 (not restricted to powers of two)
//   ADDR_W  $clog2(DEPTH)  pointer width; derived, do not override
//
// PORTS
//   clock      in   1         rising-edge clock
//   reset      in   1         synchronous, active-high reset
//   init       in   1         synchronous clear; same effect as reset
//   enq        in   1         enqueue request
//   enq_data   in   DATA_W    entry to write when enq is accepted
//   deq        in   1         dequeue request
//   deq_data   out  DATA_W    registered head entry from last accepted deq
//   deq_valid  out  1         1-cycle pulse: deq_data updated this cycle
//   full       out  1         count == DEPTH
//   empty      out  1         count == 0
//   count      out  ADDR_W+1  current occupancy, 0..DEPTH
//   overflow   out  1         sticky: enq rejected because full
//   underflow  out  1         sticky: deq rejected because empty
//
// BEHAVIOUR
//   Reset / init (either high at a rising edge):
//     - wr_ptr = 0, rd_ptr = 0, count = 0
//     - deq_data = 0, deq_valid = 0, overflow = 0, underflow = 0
//     - storage contents not cleared; they are don't-care
//   Priority: reset > init > enq/deq. init in the same cycle as enq/deq discards both.
//   Acceptance:
//     - deq_acc = deq && !empty
//     - enq_acc = enq && (!full || deq_acc)
//   On enq_acc: mem[wr_ptr] <= enq_data; wr_ptr advances, wrapping DEPTH-1 -> 0.
//   On deq_acc:
//     - deq_data <= mem[rd_ptr]; deq_valid <= 1 on the next edge
//     - rd_ptr advances with the same wrap rule
//     - latency: one cycle, request edge -> data
//   Without deq_acc: deq_valid <= 0 and deq_data holds its last value.
//   count: +1 on enq_acc only, -1 on deq_acc only, unchanged when both or neither.
//   Simultaneous enq/deq:
//     - when full, both are accepted; count stays DEPTH
//     - when empty, deq is rejected (no bypass) and enq is accepted; count becomes 1
//   Errors: overflow <= 1 when enq && !enq_acc; underflow <= 1 when deq && !deq_acc.
//     Both are cleared only by reset or init.
//   full and empty are combinational decodes of the registered count.
//   FIFO order is preserved across pointer wrap; pointers never equal DEPTH.
//
// CONFIGURATION
//   MOVE_QUEUE_HWM_EN defined:
//     - adds output hwm [ADDR_W+1], the high-water mark of count
//     - hwm <= max(hwm, next count) every cycle
//     - hwm is cleared to 0 by reset or init
//   MOVE_QUEUE_HWM_EN undefined: the hwm port and its logic are absent;
//     all other behaviour is identical.
//
// TESTING
//   1. reset, then enq 0,1,2,3 on 4 consecutive cycles -> count=4, empty=0;
//      deq x4 -> deq_data 0,1,2,3 each with deq_valid, then empty=1.
//   2. DEPTH=4: enq 5 times -> full=1 after the 4th, overflow=1 after the 5th, count=4;
//      the 5th value is never dequeued.
//   3. Full with enq=1,deq=1 for 6 cycles -> count stays 4, overflow=0,
//      output order matches input order across the wrap.
//   4. Empty with deq=1,enq=1 (data=2) -> underflow=1, deq_valid=0, count=1;
//      the next deq returns 2.
//   5. count=3, then init=1 with enq=1 -> count=0, empty=1, flags=0, deq_valid=0;
//      the enq is discarded.
//   6. HWM_EN: enq 3, deq 2, enq 1 -> hwm=3, count=2; init -> hwm=0.

Source files
------------

// File: rtl/move_queue.sv
// Circular FIFO of maze move codes between the path generator and the maze walker.
// Optional high-water-mark output enabled by defining MOVE_QUEUE_HWM_EN.
module move_queue #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init,
    input  logic              enq,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq,
    output logic [DATA_W-1:0] deq_data,
    output logic              deq_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
`ifdef MOVE_QUEUE_HWM_EN
    ,
    output logic [ADDR_W:0]   hwm
`endif
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              deq_acc;
    logic              enq_acc;
    logic              clr;

    assign clr     = reset || init;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign deq_acc = deq && !empty;
    assign enq_acc = enq && (!full || deq_acc);

    // Occupancy after this edge; shared by the count register and the high-water mark.
    always_comb begin
        count_nxt = count;
        if (enq_acc && !deq_acc) begin
            count_nxt = count + (ADDR_W+1)'(1);
        end else if (deq_acc && !enq_acc) begin
            count_nxt = count - (ADDR_W+1)'(1);
        end
    end

    // Storage is never cleared; its contents before the first write are don't-care.
    always_ff @(posedge clock) begin
        if (enq_acc && !clr) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            deq_data  <= '0;
            deq_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            deq_valid <= deq_acc;
            if (enq_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ADDR_W'(1);
            end
            if (deq_acc) begin
                deq_data <= mem[rd_ptr];
                rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ADDR_W'(1);
            end
            if (enq && !enq_acc) begin
                overflow <= 1'b1;
            end
            if (deq && !deq_acc) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef MOVE_QUEUE_HWM_EN
    always_ff @(posedge clock) begin
        if (clr) begin
            hwm <= '0;
        end else if (count_nxt > hwm) begin
            hwm <= count_nxt;
        end
    end
`endif

endmodule
